// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the 5-stage core.
//
// Serves the MEM-stage request bus with a word-addressed RAM (byte-masked
// synchronous writes, combinational reads) and a 256-byte MMIO window:
//   +0x00 CONSOLE   write pushes one byte into the console FIFO, reads 0
//   +0x04 STATUS    {16'b0, count, 5'b0, overflow, full, empty}; write clears overflow
//   +0x08 TOHOST    sticky test-termination register
//   +0x10 CYCLE_LO  low half of the free-running 64-bit cycle counter
//   +0x14 CYCLE_HI  high half
//
// Build option: define DMEM_CONSOLE_EN to build the console FIFO and STATUS
// logic. Without it the console port idles at 0 and STATUS reads 32'h1.
//
// Ports:
//   clk, reset        clock; asynchronous active-low reset
//   dmem_addr/wd/mask/we  request bus (byte address, lane-aligned data)
//   dmem_rd           combinational read data
//   cons_valid/data   console drain port (head byte), cons_ready from sink
//   tohost_valid/data sticky TOHOST indication and last written value
module dmem_responder #(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
  parameter int          FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wd,
  input  logic [3:0]  dmem_mask,
  input  logic        dmem_we,
  output logic [31:0] dmem_rd,
  output logic        cons_valid,
  output logic [7:0]  cons_data,
  input  logic        cons_ready,
  output logic        tohost_valid,
  output logic [31:0] tohost_data
);
  localparam int AW = $clog2(DEPTH_WORDS);

  // decode
  logic          mmio_hit;
  logic [5:0]    reg_sel;
  logic [AW-1:0] widx;
  assign mmio_hit = (dmem_addr[31:8] == MMIO_BASE[31:8]);
  assign reg_sel  = dmem_addr[7:2];
  assign widx     = dmem_addr[AW+1:2];

  logic wr_status, wr_tohost;
  assign wr_status = dmem_we & mmio_hit & (reg_sel == 6'h01);
  assign wr_tohost = dmem_we & mmio_hit & (reg_sel == 6'h02);

  // byte offset within the word never matters
  logic [1:0] unused_addr;
  assign unused_addr = dmem_addr[1:0];

  // RAM: not reset, so contents survive a mid-run reset
  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (dmem_we && !mmio_hit) begin
      for (int i = 0; i < 4; i++)
        if (dmem_mask[i]) mem[widx][8*i +: 8] <= dmem_wd[8*i +: 8];
    end
  end

  // TOHOST
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tohost_valid <= 1'b0;
      tohost_data  <= '0;
    end else if (wr_tohost) begin
      tohost_valid <= 1'b1;
      tohost_data  <= dmem_wd;
    end
  end

  // cycle counter: shows N after N posedges out of reset
  logic [63:0] cycle;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cycle <= '0;
    else        cycle <= cycle + 64'd1;
  end

  logic [31:0] status;

`ifdef DMEM_CONSOLE_EN
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [7:0]    fifo [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic          full, empty, push_req, push, pop;
  logic [7:0]    push_byte;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign pop   = !empty & cons_ready;
  // mask 0 carries no byte, so it pushes nothing
  assign push_req = dmem_we & mmio_hit & (reg_sel == 6'h00) & (|dmem_mask);
  // a same-cycle pop frees the slot, so a full FIFO still accepts the push
  assign push     = push_req & (!full | pop);

  // byte comes from the lowest enabled lane
  always_comb begin
    push_byte = 8'h00;
    if      (dmem_mask[0]) push_byte = dmem_wd[7:0];
    else if (dmem_mask[1]) push_byte = dmem_wd[15:8];
    else if (dmem_mask[2]) push_byte = dmem_wd[23:16];
    else if (dmem_mask[3]) push_byte = dmem_wd[31:24];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (wr_status)                   overflow <= 1'b0;
      else if (push_req && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= push_byte;
  end

  assign cons_valid = !empty;
  // storage is unreset; mask it so the port reads 0 when nothing is queued
  assign cons_data  = empty ? 8'h00 : fifo[rd_ptr];
  assign status     = {16'b0, 8'(count), 5'b0, overflow, full, empty};
`else
  logic unused_cons;
  assign unused_cons = cons_ready | wr_status;
  assign cons_valid  = 1'b0;
  assign cons_data   = 8'h00;
  assign status      = 32'h1;
`endif

  // read mux
  always_comb begin
    dmem_rd = mem[widx];
    if (mmio_hit) begin
      case (reg_sel)
        6'h01:   dmem_rd = status;
        6'h02:   dmem_rd = tohost_data;
        6'h04:   dmem_rd = cycle[31:0];
        6'h05:   dmem_rd = cycle[63:32];
        default: dmem_rd = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder. Stimulus queues expected values for
// each cycle; a negedge monitor pops and compares them, and separately
// checks every console byte drained against the queue of pushed bytes.
module tb_dmem_responder;
  localparam logic [31:0] B = 32'hFFFF_0000;
  localparam int DW = 4096;

  logic        clk = 1'b1;
  logic        reset;
  logic [31:0] dmem_addr, dmem_wd, dmem_rd, tohost_data;
  logic [3:0]  dmem_mask;
  logic        dmem_we, cons_valid, cons_ready, tohost_valid;
  logic [7:0]  cons_data;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DW), .MMIO_BASE(B), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .dmem_addr(dmem_addr), .dmem_wd(dmem_wd),
    .dmem_mask(dmem_mask), .dmem_we(dmem_we), .dmem_rd(dmem_rd),
    .cons_valid(cons_valid), .cons_data(cons_data), .cons_ready(cons_ready),
    .tohost_valid(tohost_valid), .tohost_data(tohost_data)
  );

  typedef struct { int kind; logic [31:0] exp; string name; } chk_t;
  chk_t       q[$];
  logic [7:0] cq[$];
  int nvec = 0, nerr = 0, ncyc = 0;

  // kinds: 0 rd, 1 tohost_valid, 2 tohost_data, 3 cons_valid, 4 cons_data, 5 pending bytes
  always @(negedge clk) begin
    chk_t c;
    logic [31:0] act;
    while (q.size() > 0) begin
      c = q.pop_front();
      case (c.kind)
        0: act = dmem_rd;
        1: act = {31'b0, tohost_valid};
        2: act = tohost_data;
        3: act = {31'b0, cons_valid};
        4: act = {24'b0, cons_data};
        default: act = 32'(cq.size());
      endcase
      nvec++;
      if (act !== c.exp) begin
        nerr++;
        $display("FAIL %s: got %h, expected %h", c.name, act, c.exp);
      end
    end
    if (cons_valid && cons_ready) begin
      nvec++;
      if (cq.size() == 0) begin
        nerr++;
        $display("FAIL cons_drain: got %h, expected no byte", cons_data);
      end else begin
        logic [7:0] e;
        e = cq.pop_front();
        if (cons_data !== e) begin
          nerr++;
          $display("FAIL cons_drain: got %h, expected %h", cons_data, e);
        end
      end
    end
  end

  task automatic drv(input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] m, input logic we);
    dmem_addr = a; dmem_wd = wd; dmem_mask = m; dmem_we = we;
  endtask

  task automatic ex(input int k, input logic [31:0] e, input string n);
    chk_t c;
    c.kind = k; c.exp = e; c.name = n;
    q.push_back(c);
  endtask

  task automatic step;
    @(posedge clk); #1;
    ncyc++;
  endtask

  // push one console byte in lane l (lower lanes masked off, upper lanes junk)
  task automatic cpush(input logic [7:0] b, input int l);
    logic [31:0] wd;
    wd = 32'hEEEE_EEEE;
    wd[8*l +: 8] = b;
    drv(B, wd, 4'(4'hF << l), 1'b1);
    cq.push_back(b);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; cons_ready = 1'b0;
    // preload RAM through the bus while reset is held
    drv(32'h20, 32'hDEAD_BEEF, 4'hF, 1'b1);
    ex(1, 32'h0, "rst_tohost_valid"); ex(2, 32'h0, "rst_tohost_data");
    ex(3, 32'h0, "rst_cons_valid");   ex(4, 32'h0, "rst_cons_data");
    step;
    drv(32'h100, 32'h0, 4'hF, 1'b1);
    step;
    reset = 1'b1; ncyc = 0;
    drv(B + 32'h10, 32'h0, 4'h0, 1'b0);
    ex(0, 32'h0, "cycle_lo_first");
    step;
    drv(32'h20, 32'h0, 4'h0, 1'b0);
    ex(0, 32'hDEAD_BEEF, "preload_read");
    step;

    // masked writes
    drv(32'h100, 32'hAABB_CCDD, 4'hF, 1'b1); ex(0, 32'h0, "wr_old_word");      step;
    drv(32'h100, 32'h0000_1100, 4'h2, 1'b1); ex(0, 32'hAABB_CCDD, "full_wr");  step;
    drv(32'h100, 32'hFFFF_FFFF, 4'h0, 1'b1); ex(0, 32'hAABB_11DD, "lane1_wr"); step;
    drv(32'h103, 32'h0, 4'h0, 1'b0);         ex(0, 32'hAABB_11DD, "mask0_wr"); step;

    // aliasing
    drv(DW*4 + 32'h20, 32'h1234_5678, 4'hF, 1'b1); ex(0, 32'hDEAD_BEEF, "alias_same_cycle"); step;
    drv(32'h20, 32'h0, 4'h0, 1'b0);                ex(0, 32'h1234_5678, "alias_read");       step;

    // unmapped MMIO offset
    drv(B + 32'h0C, 32'h0, 4'h0, 1'b0); ex(0, 32'h0, "mmio_unmapped"); step;

`ifdef DMEM_CONSOLE_EN
    for (int i = 0; i < 8; i++) begin
      cpush(8'(8'h41 + i), i % 4);
      ex(0, 32'h0, "console_read");
      if (i == 0) ex(3, 32'h0, "cons_valid_push_cycle");
      step;
    end
    drv(B + 4, 32'h0, 4'h0, 1'b0); ex(0, 32'h0000_0802, "status_full"); step;
    drv(B, 32'h0000_005A, 4'h1, 1'b1); ex(0, 32'h0, "console_read_ovf"); step; // dropped
    drv(B + 4, 32'h0, 4'h0, 1'b0);
    ex(0, 32'h0000_0806, "status_ovf"); ex(4, 32'h41, "cons_data_hold");
    step;
    cons_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      ex(0, {16'b0, 8'(8 - k), 8'h04} | (k == 0 ? 32'h2 : 32'h0), "status_drain");
      step;
    end
    ex(0, 32'h0000_0005, "status_drained"); ex(3, 32'h0, "cons_valid_drained");
    ex(5, 32'h0, "bytes_pending");
    step;
    drv(B + 4, 32'h0, 4'hF, 1'b1); ex(0, 32'h0000_0005, "status_wr_cycle"); step;
    drv(B + 4, 32'h0, 4'h0, 1'b0); ex(0, 32'h0000_0001, "status_ovf_clr"); step;

    // full FIFO with simultaneous push and pop
    cons_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin cpush(8'(8'h61 + i), 0); step; end
    cons_ready = 1'b1;
    cpush(8'h69, 2); step;
    cons_ready = 1'b0;
    drv(B + 4, 32'h0, 4'h0, 1'b0);
    ex(0, 32'h0000_0802, "status_full_pushpop"); ex(4, 32'h62, "cons_head_after");
    step;
    cons_ready = 1'b1;
    drv(32'h0, 32'h0, 4'h0, 1'b0);
    for (int i = 0; i < 8; i++) step;
    drv(B + 4, 32'h0, 4'h0, 1'b0);
    ex(0, 32'h0000_0001, "status_after_pushpop"); ex(5, 32'h0, "bytes_pending2");
    ex(3, 32'h0, "cons_valid_empty");
    step;
    cons_ready = 1'b0;
`else
    cons_ready = 1'b1;
    drv(B, 32'h0000_0041, 4'h1, 1'b1); ex(0, 32'h0, "console_read"); step;
    drv(B + 4, 32'h0, 4'h0, 1'b0);
    ex(0, 32'h0000_0001, "status_const"); ex(3, 32'h0, "cons_valid_off");
    ex(4, 32'h0, "cons_data_off");
    step;
    cons_ready = 1'b0;
`endif

    // TOHOST (mask ignored)
    drv(B + 8, 32'h0000_0001, 4'h0, 1'b1); ex(1, 32'h0, "tohost_valid_wr_cycle"); step;
    drv(B + 8, 32'h0, 4'h0, 1'b0);
    ex(1, 32'h1, "tohost_valid"); ex(2, 32'h1, "tohost_data"); ex(0, 32'h1, "tohost_read");
    step;
    drv(B + 8, 32'hCAFE_F00D, 4'h3, 1'b1); step;
    drv(32'h0, 32'h0, 4'h0, 1'b0);
    ex(1, 32'h1, "tohost_sticky"); ex(2, 32'hCAFE_F00D, "tohost_data2");
    step;

    // cycle counter
    while (ncyc < 100) step;
    drv(B + 32'h10, 32'h0, 4'h0, 1'b0); ex(0, 32'd100, "cycle_lo_100"); step;
    drv(B + 32'h14, 32'h0, 4'h0, 1'b0); ex(0, 32'd0, "cycle_hi");       step;

    // reset mid-operation
`ifdef DMEM_CONSOLE_EN
    cpush(8'h51, 0); step;
    drv(32'h0, 32'h0, 4'h0, 1'b0); ex(3, 32'h1, "cons_valid_before_rst"); step;
`endif
    drv(32'h100, 32'h0, 4'h0, 1'b0);
    reset = 1'b0;
    cq.delete();
    #1;
    ex(1, 32'h0, "mid_rst_tohost_valid"); ex(2, 32'h0, "mid_rst_tohost_data");
    ex(3, 32'h0, "mid_rst_cons_valid");   ex(4, 32'h0, "mid_rst_cons_data");
    ex(0, 32'hAABB_11DD, "ram_kept");
    step;
    drv(B + 32'h10, 32'h0, 4'h0, 1'b0); ex(0, 32'h0, "cycle_in_rst");
    step;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
